// File: rtl/tcam_lookup_sequencer_if.sv
// Request/response bundle between a lookup client and tcam_lookup_sequencer.
// Carries lookup, table-write, flush and response channels.
interface tcam_lookup_sequencer_if #(
    parameter int ID_Width    = 4,
    parameter int AddressSize = 4
);
    logic                     lk_valid;
    logic                     lk_ready;
    logic [ID_Width-1:0]      lk_id;

    logic                     wr_valid;
    logic                     wr_ready;
    logic [AddressSize-1:0]   wr_addr;
    logic [ID_Width-1:0]      wr_key;
    logic [ID_Width-1:0]      wr_dst;
    logic [2*ID_Width-1:0]    wr_mask;

    logic                     flush_req;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_Width-1:0]      rsp_dst;
    logic                     rsp_miss;

    modport master (
        output lk_valid, lk_id,
        output wr_valid, wr_addr, wr_key, wr_dst, wr_mask,
        output flush_req, rsp_ready,
        input  lk_ready, wr_ready, rsp_valid, rsp_dst, rsp_miss
    );

    modport slave (
        input  lk_valid, lk_id,
        input  wr_valid, wr_addr, wr_key, wr_dst, wr_mask,
        input  flush_req, rsp_ready,
        output lk_ready, wr_ready, rsp_valid, rsp_dst, rsp_miss
    );
endinterface

// File: rtl/tcam_lookup_sequencer.sv
// Lookup queue + arbiter stepping a TCAM wrapper through COMPARE/CMP_RD.
// Optional TCAM_SEQ_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module tcam_lookup_sequencer #(
    parameter int ID_Width    = 4,
    parameter int AddressSize = 4,
    parameter int FIFO_Depth  = 4,
    parameter int RESULT_LAT  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tcam_lookup_sequencer_if.slave cmd,
    output logic [2:0]             Mode_Out,
    output logic [ID_Width-1:0]    PacketID_Out,
    output logic                   Vbe_Out,
    output logic                   Dcs_Out,
    output logic                   Vbi_Out,
    output logic [2*ID_Width-1:0]  Data_Out,
    output logic [2*ID_Width-1:0]  Mskb_Out,
    output logic [AddressSize-1:0] A_Out,
    input  logic [ID_Width-1:0]    DstID_In,
`ifdef TCAM_SEQ_STATS_EN
    output logic [15:0]            hit_cnt,
    output logic [15:0]            miss_cnt,
`endif
    output logic                   busy
);

    localparam int PW = $clog2(FIFO_Depth);
    localparam int LW = $clog2(RESULT_LAT + 1);
    localparam logic [PW:0]   OCC_FULL = (PW + 1)'(FIFO_Depth);
    localparam logic [LW-1:0] LAT_END  = LW'(RESULT_LAT);

    localparam logic [2:0] MODE_I = 3'b000;
    localparam logic [2:0] MODE_W = 3'b001;
    localparam logic [2:0] MODE_F = 3'b011;
    localparam logic [2:0] MODE_C = 3'b100;

    typedef enum logic [2:0] {
        S_RST, S_IDLE, S_CMP, S_CRD,
        S_WAIT, S_RESP, S_WR, S_FLU
    } state_t;

    state_t state_q, state_d;

    logic [ID_Width-1:0] fifo_q [FIFO_Depth];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW:0]         occ_q;
    logic                full, empty, push, pop;
    logic [ID_Width-1:0] head;

    logic                flush_pend_q;
    logic                flush_any;
    logic [ID_Width-1:0] inflight_q;
    logic [LW-1:0]       lat_q;
    logic                lat_done;

    logic                rsp_valid_q;
    logic [ID_Width-1:0] rsp_dst_q;
    logic                rsp_miss_q;
    logic                rsp_fire;

    logic [2:0]             mode_d;
    logic [ID_Width-1:0]    pid_d;
    logic                   en_d;
    logic [2*ID_Width-1:0]  data_d;
    logic [2*ID_Width-1:0]  mskb_d;
    logic [AddressSize-1:0] addr_d;
    logic                   wr_rdy_d;
    logic                   wr_rdy_q;

    assign full  = (occ_q == OCC_FULL);
    assign empty = (occ_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    assign cmd.lk_ready = rst_n && !full && (state_q != S_RST);
    assign push = cmd.lk_valid && cmd.lk_ready;
    assign pop  = (state_d == S_CMP);

    assign flush_any = flush_pend_q || cmd.flush_req;
    assign lat_done  = (state_q == S_WAIT) && (lat_q == LAT_END);
    assign rsp_fire  = rsp_valid_q && cmd.rsp_ready;

    assign cmd.wr_ready  = wr_rdy_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_dst   = rsp_dst_q;
    assign cmd.rsp_miss  = rsp_miss_q;
    assign busy          = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_RST;
        else        state_q <= state_d;
    end

    // Next state, plus the wrapper drive for that state so outputs register cleanly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RST:  state_d = S_IDLE;
            S_IDLE: begin
                if (flush_any)                   state_d = S_FLU;
                else if (cmd.wr_valid)           state_d = S_WR;
                else if (!empty && !rsp_valid_q) state_d = S_CMP;
            end
            S_CMP:  state_d = S_CRD;
            S_CRD:  state_d = S_WAIT;
            S_WAIT: if (lat_done) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            S_WR:   state_d = S_IDLE;
            S_FLU:  state_d = S_IDLE;
            default: state_d = S_RST;
        endcase
        if (!rst_n) state_d = S_RST;

        mode_d   = MODE_I;
        pid_d    = '0;
        en_d     = 1'b0;
        data_d   = '0;
        mskb_d   = '0;
        addr_d   = '0;
        wr_rdy_d = 1'b0;
        unique case (1'b1)
            (state_d == S_WR): begin
                mode_d   = MODE_W;
                en_d     = 1'b1;
                addr_d   = cmd.wr_addr;
                data_d   = {cmd.wr_key, cmd.wr_dst};
                mskb_d   = cmd.wr_mask;
                wr_rdy_d = 1'b1;
            end
            (state_d == S_FLU): mode_d = MODE_F;
            (state_d == S_CMP): begin
                mode_d = MODE_C;
                pid_d  = head;
            end
            (state_d == S_CRD): pid_d = inflight_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Mode_Out     <= MODE_I;
            PacketID_Out <= '0;
            Vbe_Out      <= 1'b0;
            Dcs_Out      <= 1'b0;
            Vbi_Out      <= 1'b0;
            Data_Out     <= '0;
            Mskb_Out     <= '0;
            A_Out        <= '0;
            wr_rdy_q     <= 1'b0;
        end else begin
            Mode_Out     <= mode_d;
            PacketID_Out <= pid_d;
            Vbe_Out      <= en_d;
            Dcs_Out      <= en_d;
            Vbi_Out      <= en_d;
            Data_Out     <= data_d;
            Mskb_Out     <= mskb_d;
            A_Out        <= addr_d;
            wr_rdy_q     <= wr_rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= cmd.lk_id;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                inflight_q <= head;
            end
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: ;
            endcase
        end
    end

    // A pulse landing in the same cycle as the flush entry is covered by that flush.
    always_ff @(posedge clk) begin
        if (!rst_n)                 flush_pend_q <= 1'b0;
        else if (state_d == S_FLU)  flush_pend_q <= 1'b0;
        else if (cmd.flush_req)     flush_pend_q <= 1'b1;
    end

    // lat_q equals the number of cycles elapsed since the S_CMP cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)                lat_q <= '0;
        else if (state_d == S_CMP) lat_q <= '0;
        else if (state_q == S_CMP || state_q == S_CRD || state_q == S_WAIT)
            lat_q <= lat_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_dst_q   <= '0;
            rsp_miss_q  <= 1'b0;
        end else if (lat_done) begin
            rsp_valid_q <= 1'b1;
            rsp_dst_q   <= DstID_In;
            rsp_miss_q  <= (DstID_In == '0);
        end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef TCAM_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rsp_fire) begin
            if (rsp_miss_q) begin
                if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end else begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tcam_lookup_sequencer.sv
// Self-checking bench for tcam_lookup_sequencer with a behavioural TCAM wrapper.
// Expected results come from an address-ordered reference table kept here.
module tb_tcam_lookup_sequencer;
    localparam int IW = 4;
    localparam int AW = 4;
    localparam int FD = 4;
    localparam int RL = 3;
    localparam int LAT_EXP = RL + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tcam_lookup_sequencer_if #(.ID_Width(IW), .AddressSize(AW)) bus ();

    logic [2:0]      Mode_Out;
    logic [IW-1:0]   PacketID_Out;
    logic            Vbe_Out, Dcs_Out, Vbi_Out;
    logic [2*IW-1:0] Data_Out, Mskb_Out;
    logic [AW-1:0]   A_Out;
    logic [IW-1:0]   DstID_In;
    logic            busy;
`ifdef TCAM_SEQ_STATS_EN
    logic [15:0]     hit_cnt, miss_cnt;
`endif

    tcam_lookup_sequencer #(
        .ID_Width(IW), .AddressSize(AW),
        .FIFO_Depth(FD), .RESULT_LAT(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(bus),
        .Mode_Out(Mode_Out), .PacketID_Out(PacketID_Out),
        .Vbe_Out(Vbe_Out), .Dcs_Out(Dcs_Out), .Vbi_Out(Vbi_Out),
        .Data_Out(Data_Out), .Mskb_Out(Mskb_Out), .A_Out(A_Out),
        .DstID_In(DstID_In),
`ifdef TCAM_SEQ_STATS_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural TCAM wrapper: result appears RL cycles after the CMP cycle.
    logic          tv [16];
    logic [IW-1:0] tk [16];
    logic [IW-1:0] td [16];
    logic [IW-1:0] tm [16];
    logic [IW-1:0] pipe [RL];

    function automatic logic [IW-1:0] tcam_search(input logic [IW-1:0] pid);
        for (int i = 0; i < 16; i++)
            if (tv[i] && (((tk[i] ^ pid) & tm[i]) == '0)) return td[i];
        return '0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) tv[i] <= 1'b0;
        end else if (Mode_Out == 3'b001 && Vbe_Out && Dcs_Out && Vbi_Out) begin
            tv[A_Out] <= 1'b1;
            tk[A_Out] <= Data_Out[2*IW-1:IW];
            td[A_Out] <= Data_Out[IW-1:0];
            tm[A_Out] <= Mskb_Out[2*IW-1:IW];
        end else if (Mode_Out == 3'b011) begin
            for (int i = 0; i < 16; i++) tv[i] <= 1'b0;
        end
        pipe[0] <= (Mode_Out == 3'b100) ? tcam_search(PacketID_Out) : 4'hF;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign DstID_In = pipe[RL-1];

    logic [2:0] log_q[$];
    always @(posedge clk)
        if (Mode_Out != 3'b000) log_q.push_back(Mode_Out);

    // Reference table: entries by address, lowest matching address wins.
    bit            rv [16];
    logic [IW-1:0] rk [16];
    logic [IW-1:0] rd [16];

    function automatic logic [IW-1:0] ref_lookup(input logic [IW-1:0] id);
        for (int a = 0; a < 16; a++)
            if (rv[a] && rk[a] == id) return rd[a];
        return '0;
    endfunction

    task automatic ref_clear();
        for (int a = 0; a < 16; a++) rv[a] = 0;
    endtask

    task automatic drive_idle();
        bus.lk_valid = 0; bus.lk_id = '0;
        bus.wr_valid = 0; bus.wr_addr = '0;
        bus.wr_key = '0; bus.wr_dst = '0; bus.wr_mask = '0;
        bus.flush_req = 0; bus.rsp_ready = 1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy && !bus.rsp_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout busy=%0b rsp_valid=%0b required idle", busy, bus.rsp_valid);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [IW-1:0] k, input logic [IW-1:0] d);
        bit ok = 0;
        @(negedge clk);
        bus.wr_valid = 1; bus.wr_addr = a;
        bus.wr_key = k; bus.wr_dst = d; bus.wr_mask = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wr_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.wr_valid = 0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL write_timeout addr=%0d wr_ready never seen, required 1", a);
        end else begin
            rv[a] = 1; rk[a] = k; rd[a] = d;
        end
    endtask

    task automatic do_lookup(input logic [IW-1:0] id, input int hold,
                             output logic [IW-1:0] dst, output logic miss, output int lat);
        bit ok = 0;
        bus.rsp_ready = (hold == 0);
        @(negedge clk);
        bus.lk_id = id; bus.lk_valid = 1;
        for (int i = 0; i < 50; i++) begin
            if (bus.lk_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.lk_valid = 0; bus.lk_id = '0;
        lat = 0;
        if (ok) begin
            ok = 0;
            for (int i = 1; i <= 50; i++) begin
                @(posedge clk); #1;
                if (bus.rsp_valid) begin lat = i; ok = 1; break; end
            end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL lookup_timeout id=%0h no response, required one", id);
        end
        dst = bus.rsp_dst; miss = bus.rsp_miss;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (Mode_Out !== 3'b000) begin n_bad++; $display("FAIL rst_mode got=%0b required=000", Mode_Out); end
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_dst !== '0 || bus.rsp_miss !== 1'b0) begin
            n_bad++; $display("FAIL rst_rsp got=%0b/%0h/%0b required 0/0/0", bus.rsp_valid, bus.rsp_dst, bus.rsp_miss); end
        n_cmp++; if (bus.lk_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin
            n_bad++; $display("FAIL rst_ready got lk=%0b wr=%0b required 0/0", bus.lk_ready, bus.wr_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got=%0b required=1", busy); end
        n_cmp++; if ({PacketID_Out, Data_Out, Mskb_Out, A_Out, Vbe_Out, Dcs_Out, Vbi_Out} !== '0) begin
            n_bad++; $display("FAIL rst_wrapper_outs got pid=%0h data=%0h a=%0h required all 0", PacketID_Out, Data_Out, A_Out); end
        rst_n = 1;
        ref_clear();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || bus.lk_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_exit got busy=%0b lk_ready=%0b required 0/1", busy, bus.lk_ready); end
    endtask

    task automatic test_write_lookup();
        logic [IW-1:0] d; logic m; int lat;
        do_write(4'd3, 4'h5, 4'hA);
        wait_idle();
        do_lookup(4'h5, 0, d, m, lat);
        n_cmp++; if (d !== 4'hA) begin n_bad++; $display("FAIL hit_dst got=%0h required=%0h", d, 4'hA); end
        n_cmp++; if (m !== 1'b0) begin n_bad++; $display("FAIL hit_miss got=%0b required=0", m); end
        n_cmp++; if (lat != LAT_EXP) begin n_bad++; $display("FAIL hit_latency got=%0d required=%0d", lat, LAT_EXP); end
    endtask

    task automatic test_miss();
        logic [IW-1:0] d; logic m; int lat;
        wait_idle();
        do_lookup(4'h7, 0, d, m, lat);
        n_cmp++; if (d !== 4'h0 || m !== 1'b1) begin n_bad++; $display("FAIL miss_rsp got=%0h/%0b required 0/1", d, m); end
        n_cmp++; if (lat != LAT_EXP) begin n_bad++; $display("FAIL miss_latency got=%0d required=%0d", lat, LAT_EXP); end
    endtask

    task automatic test_fifo_full();
        logic [IW-1:0] ids [8];
        logic [IW-1:0] got [$];
        int acc = 0;
        int held_bad = 0;
        bit ok;
        wait_idle();
        for (int i = 0; i < 8; i++) ids[i] = IW'($urandom_range(0, 15));
        bus.rsp_ready = 0;
        for (int c = 0; c < 30 && acc < 8; c++) begin
            @(negedge clk);
            bus.lk_valid = 1; bus.lk_id = ids[acc];
            if (bus.lk_ready) begin @(posedge clk); acc++; end
        end
        @(negedge clk);
        n_cmp++; if (bus.lk_ready !== 1'b0) begin n_bad++; $display("FAIL full_lk_ready got=%0b required=0", bus.lk_ready); end
        bus.lk_valid = 0;
        // One lookup is in flight and blocked; the queue holds FD more.
        n_cmp++; if (acc != FD + 1) begin n_bad++; $display("FAIL full_accepted got=%0d required=%0d", acc, FD + 1); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_dst !== ref_lookup(ids[0]) || Mode_Out == 3'b100) held_bad++;
        end
        n_cmp++; if (held_bad != 0) begin n_bad++; $display("FAIL full_held_rsp bad_cycles=%0d required=0", held_bad); end
        got.push_back(bus.rsp_dst);
        bus.rsp_ready = 1;
        ok = 1;
        for (int c = 0; c < 200 && got.size() < acc; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) got.push_back(bus.rsp_dst);
        end
        if (got.size() < acc) ok = 0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_drain got=%0d responses required=%0d", got.size(), acc); end
        for (int i = 0; i < acc && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== ref_lookup(ids[i])) begin
                n_bad++; $display("FAIL full_order idx=%0d id=%0h got=%0h required=%0h", i, ids[i], got[i], ref_lookup(ids[i]));
            end
        end
    endtask

    task automatic test_flush_write();
        logic [IW-1:0] d; logic m; int lat; int start; bit ok = 0;
        do_write(4'd1, 4'h9, 4'h3);
        wait_idle();
        start = log_q.size();
        @(negedge clk);
        bus.flush_req = 1;
        bus.wr_valid = 1; bus.wr_addr = 4'd2;
        bus.wr_key = 4'hC; bus.wr_dst = 4'h6; bus.wr_mask = 8'hFF;
        @(posedge clk); #1;
        bus.flush_req = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.wr_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.wr_valid = 0;
        ref_clear();
        rv[2] = 1; rk[2] = 4'hC; rd[2] = 4'h6;
        wait_idle();
        n_cmp++;
        if (!ok || log_q.size() - start != 2 || log_q[start] !== 3'b011 || log_q[start+1] !== 3'b001) begin
            n_bad++; $display("FAIL flush_then_write modes_seen=%0d first=%0b required F then W", log_q.size() - start, log_q[start]);
        end
        do_lookup(4'h9, 0, d, m, lat);
        n_cmp++; if (d !== ref_lookup(4'h9) || m !== 1'b1) begin n_bad++; $display("FAIL flushed_key got=%0h/%0b required 0/1", d, m); end
        do_lookup(4'hC, 0, d, m, lat);
        n_cmp++; if (d !== ref_lookup(4'hC) || m !== 1'b0) begin n_bad++; $display("FAIL post_flush_write got=%0h/%0b required=%0h/0", d, m, ref_lookup(4'hC)); end
    endtask

    task automatic test_random();
        logic [IW-1:0] d, e, id; logic m; int lat;
        for (int n = 0; n < 40; n++) begin
            int r = $urandom_range(0, 9);
            wait_idle();
            if (r < 4) begin
                do_write(AW'($urandom_range(0, 15)), IW'($urandom_range(0, 15)), IW'($urandom_range(1, 14)));
            end else if (r == 4) begin
                @(negedge clk); bus.flush_req = 1;
                @(negedge clk); bus.flush_req = 0;
                ref_clear();
            end else begin
                id = IW'($urandom_range(0, 15));
                e = ref_lookup(id);
                do_lookup(id, $urandom_range(0, 3), d, m, lat);
                n_cmp++;
                if (d !== e || m !== (e == '0)) begin
                    n_bad++; $display("FAIL rand_lookup id=%0h got=%0h/%0b required=%0h/%0b", id, d, m, e, e == '0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0; bit ok = 0;
        wait_idle();
        @(negedge clk); bus.lk_valid = 1; bus.lk_id = 4'hC;
        @(posedge clk); #1 bus.lk_id = 4'h9;
        @(posedge clk); #1 bus.lk_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Mode_Out == 3'b100) begin ok = 1; break; end
        end
        repeat (2) @(negedge clk);
        rst_n = 0;
        @(posedge clk); #1;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL midrst_no_cmp Mode C never seen, required it"); end
        n_cmp++; if (bus.rsp_valid !== 1'b0 || Mode_Out !== 3'b000) begin
            n_bad++; $display("FAIL midrst_outs got rsp_valid=%0b mode=%0b required 0/000", bus.rsp_valid, Mode_Out); end
        n_cmp++; if (busy !== 1'b1 || bus.lk_ready !== 1'b0) begin
            n_bad++; $display("FAIL midrst_state got busy=%0b lk_ready=%0b required 1/0", busy, bus.lk_ready); end
        @(negedge clk);
        rst_n = 1;
        ref_clear();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || Mode_Out == 3'b100) bad++;
        end
        n_cmp++; if (bad != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL midrst_discard stray_cycles=%0d busy=%0b required 0/0", bad, busy); end
    endtask

`ifdef TCAM_SEQ_STATS_EN
    task automatic test_stats();
        logic [IW-1:0] d; logic m; int lat;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        ref_clear();
        do_write(4'd0, 4'h1, 4'h2);
        for (int i = 0; i < 5; i++) begin
            wait_idle();
            do_lookup(i < 3 ? 4'h1 : 4'h8, 0, d, m, lat);
        end
        @(negedge clk);
        n_cmp++; if (hit_cnt !== 16'd3) begin n_bad++; $display("FAIL stats_hit got=%0d required=3", hit_cnt); end
        n_cmp++; if (miss_cnt !== 16'd2) begin n_bad++; $display("FAIL stats_miss got=%0d required=2", miss_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_lookup();
        test_miss();
        test_fifo_full();
        test_flush_write();
        test_random();
        test_reset_mid();
`ifdef TCAM_SEQ_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
